// File: rtl/fifo_stream_reader_pkg.sv
// Shared types and constants for the FIFO-to-stream reader.
// State encoding is fixed so it can be observed directly on a debug bus.
package fifo_stream_reader_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int BUF_DEPTH = 3;

   // A read may only be issued if every word already owed to the buffer still fits.
   function automatic logic room_for_issue(input logic [1:0] occ, input logic inflight);
      return ({1'b0, occ} + {2'b0, inflight}) <= 3'd2;
   endfunction

endpackage

// File: rtl/stream_out_buf.sv
// Three-entry in-order {last,data} buffer presenting its head as a valid/ready stream.
// Entry 0 is always the head; a pop shifts the remaining entries down by one.
module stream_out_buf
   import fifo_stream_reader_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             push_last,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_data,
   output logic             m_last,
   output logic [1:0]       occ
);

   logic [BUF_DEPTH-1:0][WIDTH-1:0] data_q, data_n;
   logic [BUF_DEPTH-1:0]            last_q, last_n;
   logic                            pop;
   logic [1:0]                      wr_idx;

   assign m_valid = (occ != 2'd0);
   assign m_data  = data_q[0];
   assign m_last  = last_q[0];

   always_comb begin
      pop    = m_valid & m_ready;
      wr_idx = occ - {1'b0, pop};
      data_n = data_q;
      last_n = last_q;
      if (pop) begin
         for (int i = 0; i < BUF_DEPTH - 1; i++) begin
            data_n[i] = data_q[i+1];
            last_n[i] = last_q[i+1];
         end
      end
      // Push lands behind the shifted contents, so a same-cycle push+pop keeps order.
      if (push) begin
         data_n[wr_idx] = push_data;
         last_n[wr_idx] = push_last;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         data_q <= '0;
         last_q <= '0;
         occ    <= 2'd0;
      end else begin
         data_q <= data_n;
         last_q <= last_n;
         occ    <= occ + {1'b0, push} - {1'b0, pop};
      end
   end

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a 1-cycle-latency FIFO read port into a valid/ready stream, moving a
// requested number of words per transfer and flagging the final one.
module fifo_stream_reader
   import fifo_stream_reader_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int LEN_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   output logic             busy,
   output logic             done,
   output logic             fifo_re,
   input  logic [WIDTH-1:0] fifo_dout,
   input  logic             fifo_empty,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_data,
   output logic             m_last
);

   state_t           state, state_nxt;
   logic [LEN_W-1:0] issue_rem;
   logic             inflight;
   logic             inflight_last;
   logic [1:0]       occ;

   // Issue depends only on registered state and the FIFO's registered empty flag.
   assign fifo_re = (state == RUN) && (issue_rem != '0) && !fifo_empty
                    && room_for_issue(occ, inflight);
   assign busy    = (state != IDLE);
   assign done    = (state == DONE);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = (len == '0) ? DONE : RUN;
         RUN:     if (issue_rem == '0) state_nxt = DRAIN;
         DRAIN:   if ((occ == 2'd0) && !inflight) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         issue_rem     <= '0;
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
      end else begin
         state <= state_nxt;
         if ((state == IDLE) && start) issue_rem <= len;
         else if (fifo_re)             issue_rem <= issue_rem - LEN_W'(1);
         inflight      <= fifo_re;
         inflight_last <= fifo_re && (issue_rem == LEN_W'(1));
      end
   end

   stream_out_buf #(.WIDTH(WIDTH)) u_buf (
      .clk       (clk),
      .reset     (reset),
      .push      (inflight),
      .push_data (fifo_dout),
      .push_last (inflight_last),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (m_data),
      .m_last    (m_last),
      .occ       (occ)
   );

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: behavioural FIFO on the read side, scoreboard on the stream side.
module tb_fifo_stream_reader;

   localparam int WIDTH = 32;
   localparam int LEN_W = 16;

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   logic [LEN_W-1:0] len;
   logic             busy, done, fifo_re;
   logic [WIDTH-1:0] fifo_dout = '0;
   logic             fifo_empty = 1'b1;
   logic             m_valid, m_ready, m_last;
   logic [WIDTH-1:0] m_data;

   int errors = 0;
   int checks = 0;
   int re_cnt = 0, done_cnt = 0, pop_cnt = 0;

   logic [WIDTH:0]   exp_q[$];
   logic [WIDTH-1:0] fq[$];
   logic [WIDTH-1:0] wr_pend[$];
   logic             flush_req = 1'b0;

   logic             stall_prev = 1'b0;
   logic [WIDTH-1:0] prev_data;
   logic             prev_last;
   logic [WIDTH:0]   mon_e;

   always #5 clk = ~clk;

   fifo_stream_reader #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .len        (len),
      .busy       (busy),
      .done       (done),
      .fifo_re    (fifo_re),
      .fifo_dout  (fifo_dout),
      .fifo_empty (fifo_empty),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data),
      .m_last     (m_last)
   );

   // Behavioural FIFO: 1-cycle read latency, registered empty flag.
   always @(posedge clk) begin
      if (fifo_re === 1'b1) begin
         checks++;
         if (fq.size() == 0) begin
            errors++;
            $display("FAIL fifo_re_on_empty: fifo_re=1 while FIFO holds 0 words, required no read");
         end else begin
            fifo_dout <= fq.pop_front();
         end
      end
      if (flush_req) fq.delete();
      while (wr_pend.size() > 0) fq.push_back(wr_pend.pop_front());
      fifo_empty <= (fq.size() == 0);
   end

   // Stream monitor: scoreboard pops and hold-stability under backpressure.
   always @(negedge clk) begin
      if (reset !== 1'b0) begin
         stall_prev = 1'b0;
      end else begin
         if (fifo_re === 1'b1) re_cnt++;
         if (done === 1'b1) done_cnt++;
         if (stall_prev) begin
            checks++;
            if (m_valid !== 1'b1 || m_data !== prev_data || m_last !== prev_last) begin
               errors++;
               $display("FAIL hold_stable: got valid=%b data=%h last=%b, required valid=1 data=%h last=%b",
                        m_valid, m_data, m_last, prev_data, prev_last);
            end
         end
         if (m_valid === 1'b1 && m_ready === 1'b1) begin
            checks++;
            pop_cnt++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_word: got data=%h last=%b, required no word", m_data, m_last);
            end else begin
               mon_e = exp_q.pop_front();
               if ({m_last, m_data} !== mon_e) begin
                  errors++;
                  $display("FAIL stream_word: got last=%b data=%h, required last=%b data=%h",
                           m_last, m_data, mon_e[WIDTH], mon_e[WIDTH-1:0]);
               end
            end
         end
         stall_prev = (m_valid === 1'b1) && (m_ready !== 1'b1);
         prev_data  = m_data;
         prev_last  = m_last;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, required normal completion");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fifo_write(input logic [WIDTH-1:0] base, input int n);
      for (int i = 0; i < n; i++) wr_pend.push_back(base + WIDTH'(i));
   endtask

   task automatic expect_words(input logic [WIDTH-1:0] base, input int n, input logic with_last);
      for (int i = 0; i < n; i++)
         exp_q.push_back({with_last && (i == n - 1), base + WIDTH'(i)});
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; len = '0; m_ready = 1'b0;
      tick(); tick();
      checks++;
      if ({busy, done, fifo_re, m_valid, m_last} !== 5'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got busy,done,re,valid,last=%b, required 00000",
                  {busy, done, fifo_re, m_valid, m_last});
      end
      checks++;
      if (m_data !== '0) begin
         errors++;
         $display("FAIL reset_data: got m_data=%h, required 0", m_data);
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      int re_first = -1, re_last = -1, re_n = 0;
      int v_first = -1, v_last = -1, v_n = 0;
      int done_at = -1, done_n = 0, busy_n = 0;
      m_ready = 1'b1;
      fifo_write(32'hA0, 4);
      expect_words(32'hA0, 4, 1'b1);
      tick();
      start = 1'b1; len = 16'd4;
      tick();
      start = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         if (fifo_re === 1'b1) begin if (re_first < 0) re_first = i; re_last = i; re_n++; end
         if (m_valid === 1'b1) begin if (v_first < 0) v_first = i; v_last = i; v_n++; end
         if (done === 1'b1) begin done_at = i; done_n++; end
         if (busy === 1'b1) busy_n++;
         tick();
      end
      checks++;
      if (re_first != 1 || re_last != 4 || re_n != 4) begin
         errors++;
         $display("FAIL basic_re: got first=%0d last=%0d n=%0d, required 1 4 4", re_first, re_last, re_n);
      end
      checks++;
      if (v_first != 3 || v_last != 6 || v_n != 4) begin
         errors++;
         $display("FAIL basic_valid: got first=%0d last=%0d n=%0d, required 3 6 4", v_first, v_last, v_n);
      end
      checks++;
      if (done_at != 8 || done_n != 1) begin
         errors++;
         $display("FAIL basic_done: got at=%0d n=%0d, required at=8 n=1", done_at, done_n);
      end
      checks++;
      if (busy_n != 8 || busy !== 1'b0 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL basic_busy: got busy_cycles=%0d busy=%b pending=%0d, required 8 0 0",
                  busy_n, busy, exp_q.size());
      end
   endtask

   task automatic test_backpressure();
      int r0 = re_cnt, d0 = done_cnt, p0 = pop_cnt;
      m_ready = 1'b0;
      fifo_write(32'hB0, 8);
      expect_words(32'hB0, 8, 1'b1);
      tick();
      start = 1'b1; len = 16'd8;
      tick();
      start = 1'b0;
      for (int i = 0; i < 12; i++) tick();
      checks++;
      if (re_cnt - r0 != 3) begin
         errors++;
         $display("FAIL bp_issue_stop: got %0d reads, required 3", re_cnt - r0);
      end
      checks++;
      if (m_valid !== 1'b1 || m_data !== 32'hB0 || m_last !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL bp_head: got valid=%b data=%h last=%b busy=%b, required 1 b0 0 1",
                  m_valid, m_data, m_last, busy);
      end
      m_ready = 1'b1;
      for (int i = 0; i < 60 && done_cnt == d0; i++) tick();
      checks++;
      if (done_cnt != d0 + 1 || re_cnt - r0 != 8 || pop_cnt - p0 != 8 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL bp_complete: got done=%0d reads=%0d words=%0d pending=%0d, required 1 8 8 0",
                  done_cnt - d0, re_cnt - r0, pop_cnt - p0, exp_q.size());
      end
      tick();
   endtask

   task automatic test_starve();
      int r0 = re_cnt, d0 = done_cnt, p0 = pop_cnt;
      m_ready = 1'b1;
      fifo_write(32'hC0, 1);
      expect_words(32'hC0, 3, 1'b1);
      tick();
      start = 1'b1; len = 16'd3;
      tick();
      start = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      checks++;
      if (re_cnt - r0 != 1 || pop_cnt - p0 != 1 || busy !== 1'b1 || done_cnt != d0) begin
         errors++;
         $display("FAIL starve_wait: got reads=%0d words=%0d busy=%b done=%0d, required 1 1 1 0",
                  re_cnt - r0, pop_cnt - p0, busy, done_cnt - d0);
      end
      fifo_write(32'hC1, 2);
      for (int i = 0; i < 40 && done_cnt == d0; i++) tick();
      checks++;
      if (done_cnt != d0 + 1 || re_cnt - r0 != 3 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL starve_complete: got done=%0d reads=%0d pending=%0d, required 1 3 0",
                  done_cnt - d0, re_cnt - r0, exp_q.size());
      end
      tick();
   endtask

   task automatic test_zero_len();
      int r0 = re_cnt, d0;
      start = 1'b1; len = 16'd0;
      tick();
      start = 1'b0;
      checks++;
      if (done !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL zero_done: got done=%b busy=%b, required 1 1", done, busy);
      end
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || re_cnt != r0) begin
         errors++;
         $display("FAIL zero_after: got done=%b busy=%b reads=%0d, required 0 0 0",
                  done, busy, re_cnt - r0);
      end
      r0 = re_cnt;
      d0 = done_cnt;
      fifo_write(32'hD0, 4);
      expect_words(32'hD0, 2, 1'b1);
      tick();
      start = 1'b1; len = 16'd2;
      tick();
      start = 1'b1; len = 16'd5;
      tick();
      start = 1'b0;
      for (int i = 0; i < 40 && done_cnt == d0; i++) tick();
      for (int i = 0; i < 6; i++) tick();
      checks++;
      if (done_cnt != d0 + 1 || re_cnt - r0 != 2 || exp_q.size() != 0 || fq.size() != 2 || busy !== 1'b0) begin
         errors++;
         $display("FAIL busy_start_ignored: got done=%0d reads=%0d pending=%0d left=%0d busy=%b, required 1 2 0 2 0",
                  done_cnt - d0, re_cnt - r0, exp_q.size(), fq.size(), busy);
      end
      flush_req = 1'b1;
      tick();
      flush_req = 1'b0;
   endtask

   task automatic test_reset_mid();
      int r0, d0 = done_cnt, p0 = pop_cnt;
      m_ready = 1'b1;
      fifo_write(32'hE0, 6);
      expect_words(32'hE0, 3, 1'b0);
      tick();
      start = 1'b1; len = 16'd6;
      tick();
      start = 1'b0;
      for (int i = 0; i < 30 && pop_cnt < p0 + 3; i++) tick();
      reset = 1'b1;
      m_ready = 1'b0;
      tick();
      checks++;
      if ({busy, done, fifo_re, m_valid, m_last} !== 5'b0 || m_data !== '0) begin
         errors++;
         $display("FAIL midreset_outputs: got busy,done,re,valid,last=%b data=%h, required 00000 0",
                  {busy, done, fifo_re, m_valid, m_last}, m_data);
      end
      reset = 1'b0;
      flush_req = 1'b1;
      tick();
      flush_req = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      checks++;
      if (done_cnt != d0 || pop_cnt - p0 != 3 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL midreset_abandon: got done=%0d words=%0d pending=%0d, required 0 3 0",
                  done_cnt - d0, pop_cnt - p0, exp_q.size());
      end
      r0 = re_cnt;
      d0 = done_cnt;
      m_ready = 1'b1;
      fifo_write(32'hF0, 2);
      expect_words(32'hF0, 2, 1'b1);
      tick();
      start = 1'b1; len = 16'd2;
      tick();
      start = 1'b0;
      for (int i = 0; i < 40 && done_cnt == d0; i++) tick();
      checks++;
      if (done_cnt != d0 + 1 || re_cnt - r0 != 2 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL midreset_restart: got done=%0d reads=%0d pending=%0d, required 1 2 0",
                  done_cnt - d0, re_cnt - r0, exp_q.size());
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_starve();
      test_zero_len();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
